// File: rtl/mips_dbg_pkg.sv
// Shared command codes, dump layout and FSM encoding for the MIPS debug controller.
package mips_dbg_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RST  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam int unsigned DUMP_BYTES = 21;
  localparam int unsigned DUMP_W     = DUMP_BYTES * 8;

  localparam int unsigned ST_HALT    = 0;
  localparam int unsigned ST_TIMEOUT = 1;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    LOAD_WR,
    RUN,
    STEP,
    CAPTURE,
    SEND,
    ACK,
    MRST
  } dbg_state_t;

endpackage

// File: rtl/mips_dbg_dump_ser.sv
// Snapshot serializer: loads the full dump in one cycle and emits it MSB byte first
// over a valid/ready handshake, pulsing done after the last byte is accepted.
module mips_dbg_dump_ser
  import mips_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DUMP_W-1:0] load_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  logic [DUMP_W-1:0] shreg;
  logic [4:0]        byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg    <= load_data;
        tx_data  <= load_data[DUMP_W-1 -: 8];
        tx_valid <= 1'b1;
        byte_cnt <= '0;
      end else if (tx_valid && tx_ready) begin
        if (byte_cnt == 5'(DUMP_BYTES - 1)) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 5'd1;
          shreg    <= {shreg[DUMP_W-9:0], 8'h00};
          // shreg still holds the just-accepted byte on top, so the next one sits below it
          tx_data  <= shreg[DUMP_W-9 -: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host-link debug sequencer for TOP_MIPS: instruction load, run-to-halt, single step,
// core reset, and a post-run state dump back over the byte link.
module mips_debug_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned MAX_RUN_CYCLES = 4096,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mips_en,
  output logic              mips_rst_n,
  output logic              debug_flag,
  output logic              wea_ram_inst,
  output logic [DATA_W-1:0] in_addr_mem_inst,
  output logic [DATA_W-1:0] in_ins_to_mem,
  input  logic              halt_flag,
  input  logic [DATA_W-1:0] out_pc,
  input  logic [DATA_W-1:0] latch_12,
  input  logic [DATA_W-1:0] latch_23,
  input  logic [DATA_W-1:0] latch_34,
  input  logic [DATA_W-1:0] latch_45
);

  dbg_state_t  state;
  logic [7:0]  word_cnt;
  logic [7:0]  word_idx;
  logic [1:0]  byte_cnt;
  logic [15:0] run_cnt;
  logic [7:0]  status;
  logic        step_mode;
  logic        ack_valid;
  logic        timeout;

  logic [7:0]        snap_status;
  logic [DUMP_W-1:0] snap;
  logic              ser_load;
  logic [7:0]        ser_data;
  logic              ser_valid;
  logic              ser_done;

  assign timeout = mips_en && (run_cnt == 16'(MAX_RUN_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mips_en          <= 1'b0;
      mips_rst_n       <= 1'b1;
      debug_flag       <= 1'b0;
      wea_ram_inst     <= 1'b0;
      in_addr_mem_inst <= '0;
      in_ins_to_mem    <= '0;
      word_cnt         <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      run_cnt          <= '0;
      status           <= '0;
      step_mode        <= 1'b0;
      ack_valid        <= 1'b0;
    end else begin
      wea_ram_inst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_LOAD: begin
                debug_flag <= 1'b1;
                state      <= LOAD_CNT;
              end
              CMD_CONT: begin
                // a core already halted gets zero enabled cycles
                mips_en   <= !halt_flag;
                run_cnt   <= '0;
                status    <= '0;
                step_mode <= 1'b0;
                state     <= RUN;
              end
              CMD_STEP: begin
                mips_en   <= 1'b1;
                status    <= '0;
                step_mode <= 1'b1;
                state     <= STEP;
              end
              CMD_RST: begin
                mips_rst_n <= 1'b0;
                state      <= MRST;
              end
              default: ;
            endcase
          end
        end
        LOAD_CNT: begin
          if (rx_valid) begin
            word_cnt <= rx_data;
            word_idx <= '0;
            byte_cnt <= '0;
            if (rx_data == 8'h00) begin
              debug_flag <= 1'b0;
              state      <= ACK;
            end else begin
              state <= LOAD_BYTE;
            end
          end
        end
        LOAD_BYTE: begin
          if (rx_valid) begin
            in_ins_to_mem <= {in_ins_to_mem[DATA_W-9:0], rx_data};
            byte_cnt      <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wea_ram_inst     <= 1'b1;
              in_addr_mem_inst <= DATA_W'({word_idx, 2'b00});
              state            <= LOAD_WR;
            end
          end
        end
        LOAD_WR: begin
          word_idx <= word_idx + 8'd1;
          if (word_idx + 8'd1 == word_cnt) begin
            debug_flag <= 1'b0;
            state      <= ACK;
          end else begin
            state <= LOAD_BYTE;
            // the write strobe has already used the word, so a byte landing here starts the next one
            if (rx_valid) begin
              in_ins_to_mem <= {in_ins_to_mem[DATA_W-9:0], rx_data};
              byte_cnt      <= 2'd1;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 16'(mips_en);
          if (halt_flag || timeout) begin
            mips_en             <= 1'b0;
            status[ST_HALT]     <= halt_flag;
            status[ST_TIMEOUT]  <= timeout;
            state               <= CAPTURE;
          end
        end
        STEP: begin
          mips_en <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: state <= SEND;
        SEND: begin
          if (ser_done) state <= IDLE;
        end
        ACK: begin
          if (!ack_valid) begin
            ack_valid <= 1'b1;
          end else if (tx_ready) begin
            ack_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MRST: begin
          mips_rst_n <= 1'b1;
          state      <= ACK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    snap_status = status;
    if (step_mode) snap_status[ST_HALT] = halt_flag;
  end

  assign snap     = {snap_status, out_pc, latch_12, latch_23, latch_34, latch_45};
  assign ser_load = (state == CAPTURE);

  mips_dbg_dump_ser u_dump_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_data (snap),
    .tx_data   (ser_data),
    .tx_valid  (ser_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

  assign tx_valid = ser_valid | ack_valid;
  assign tx_data  = ser_valid ? ser_data : (ack_valid ? ACK_BYTE : 8'h00);

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Byte-stream debug controller that sequences TOP_MIPS from a host link (UART rx/tx byte interface).
- Receives commands to load instruction memory, run continuously to halt, single-step, and reset the core.
- After each run or step it freezes the core and streams back a state snapshot: PC plus the four inter-stage latch words.
- Sits between the UART and TOP_MIPS; owns debug_flag, wea_ram_inst, in_addr_mem_inst, in_ins_to_mem and the core clock enable.

Parameters:
- MAX_RUN_CYCLES, 4096, continuous-run timeout in core cycles (16-bit counter).
- DATA_W, 32, core word width.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts when tx_valid&&tx_ready.
- mips_en  out  1  core clock enable; the core advances one cycle per high cycle.
- mips_rst_n  out  1  core reset, active-low, one-cycle pulse.
- debug_flag  out  1  high while instruction memory is owned by the loader.
- wea_ram_inst  out  1  instruction memory write strobe.
- in_addr_mem_inst  out  32  instruction write byte address.
- in_ins_to_mem  out  32  instruction write data.
- halt_flag  in  1  core halted.
- out_pc, latch_12, latch_23, latch_34, latch_45  in  32 each  snapshot sources.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, mips_en=0, mips_rst_n=1, debug_flag=0, wea_ram_inst=0, addr=0, data=0, state IDLE, all counters 0.
- Commands, accepted only in IDLE; bytes received in any other non-LOAD state are dropped.
  - 0x4C 'L': load.
  - 0x43 'C': continuous run.
  - 0x53 'S': single step.
  - 0x52 'R': core reset.
  - Any other byte is ignored.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, CAPTURE, SEND, ACK, MRST.
- LOAD:
  - IDLE -'L'-> LOAD_CNT, debug_flag=1.
  - Next byte is word count N. If N=0, go to ACK.
  - Otherwise LOAD_BYTE collects 4 bytes MSB first, then LOAD_WR.
  - LOAD_WR asserts wea_ram_inst for exactly 1 cycle with addr=4*idx and the assembled word; idx increments.
  - After N words go to ACK. debug_flag drops when entering ACK.
  - A byte arriving during LOAD_WR is captured (LOAD_WR lasts one cycle; no loss).
- ACK: tx 0x4B, then IDLE.
- RUN:
  - mips_en=1 from the cycle after 'C'.
  - halt_flag sampled high: mips_en=0 the next cycle, then CAPTURE with status bit0=1.
  - Run counter reaches MAX_RUN_CYCLES: mips_en=0, then CAPTURE with status bit1=1.
  - If halt and timeout occur in the same cycle, both bits are set.
  - If halt_flag is already high on entry, zero core cycles run; status=0x01.
- STEP:
  - mips_en=1 for exactly one cycle, then CAPTURE.
  - status bit0 = halt_flag sampled in CAPTURE.
  - A step while halted still pulses mips_en.
- CAPTURE: one cycle with mips_en=0. Registers status, out_pc, latch_12..latch_45 into a 168-bit snapshot.
- SEND:
  - 21 bytes in order: status, PC, L12, L23, L34, L45; each word MSB first.
  - One byte per accepted handshake; tx_data stable while tx_valid=1 and tx_ready=0.
  - Returns to IDLE after byte 21 is accepted.
- MRST: mips_rst_n=0 for 1 cycle, then tx ACK 0x4B, then IDLE. Instruction memory contents are unaffected.
- Mid-operation reset: any state returns to reset values immediately. The partial word, snapshot and counters are discarded; no ack is sent.

Decomposition:
- Package mips_dbg_pkg holds:
  - command codes 0x4C/0x43/0x53/0x52;
  - ACK_BYTE 0x4B;
  - DUMP_BYTES=21;
  - status bit indices;
  - state encoding.
- Sub-module mips_dbg_dump_ser: 168-bit load, byte-wise valid/ready serializer with 5-bit byte counter and done pulse.

Test Plan:
- 'L',0x02,0x20,0x01,0x00,0x05,0x00,0x00,0x00,0x3F -> two 1-cycle wea_ram_inst pulses, with (addr 0x0, data 0x20010005) and (addr 0x4, data 0x0000003F). debug_flag is high over the whole sequence. Then tx 0x4B.
- 'S' with core PC=0x00000008 and latches 0x11111111..0x44444444 -> exactly one mips_en cycle. Then 21 bytes: 0x00,00,00,00,08,11,11,11,11,...,44,44,44,44.
- 'C' with halt_flag asserted on the 7th enabled cycle -> mips_en high for 7 cycles. First tx byte is 0x01.
- 'C' with halt never set, MAX_RUN_CYCLES=16 -> mips_en high exactly 16 cycles; status byte 0x02.
- Hold tx_ready=0 for 10 cycles mid-dump -> tx_data/tx_valid stable; no byte skipped or duplicated. Send 'S' during the dump -> ignored.
- Assert reset low during LOAD_BYTE after 2 bytes -> all outputs return to reset values. A following 'R' gives a 1-cycle mips_rst_n low, then 0x4B.
